// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply-divide unit with internal HI/LO result registers.
// Latency: done pulses in the cycle after edge E0+WIDTH+2 (E0+0 for divide-by-zero).
// Backpressure: none; start is sampled only in IDLE, and a start while busy is dropped, not queued.
// Build option MULDIV_UNSIGNED_EN: op[0] selects unsigned MULTU/DIVU; when it is undefined, every op is signed.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     opa_q, opa_d;      // |a|: multiplicand
   logic [WIDTH-1:0]     opb_q, opb_d;      // |b|: divisor
   logic [2*WIDTH-1:0]   acc_q, acc_d;      // product, or the dividend/quotient shift register in the low half
   logic [WIDTH-1:0]     rem_q, rem_d;      // restoring-division remainder
   logic                 is_div_q, is_div_d;
   logic                 neg_q, neg_d;      // quotient or product is negated in FIX
   logic                 sa_q, sa_d;        // dividend sign, which the remainder takes
   logic                 dz_q, dz_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic                 sgn_en;
   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix;
   logic [WIDTH-1:0]     rem_fix;

`ifdef MULDIV_UNSIGNED_EN
   assign sgn_en = ~op[0];
`else
   // op[0] has no meaning in this build, so it is tied off here.
   logic unused_op0;
   assign unused_op0 = op[0];
   assign sgn_en     = 1'b1;
`endif

   // Operand magnitudes. MIN maps to the unsigned value 2^(WIDTH-1).
   assign a_neg = sgn_en & a[WIDTH-1];
   assign b_neg = sgn_en & b[WIDTH-1];
   assign abs_a = a_neg ? (~a + WIDTH'(1)) : a;
   assign abs_b = b_neg ? (~b + WIDTH'(1)) : b;

   // One shift-add step: add the multiplicand to the upper half when the multiplier LSB is set.
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
   // One restoring step on the (WIDTH+1)-bit partial remainder.
   assign div_shift = {rem_q, acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opb_q};
   assign div_ge    = ~div_diff[WIDTH];

   // Sign fix-up. Signed MIN / -1 wraps back to MIN with no flag.
   assign prod_fix = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
   assign quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
   assign rem_fix  = sa_q ? (~rem_q + WIDTH'(1)) : rem_q;

   // Next-state and datapath update for every register.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               opa_d    = abs_a;
               opb_d    = abs_b;
               sa_d     = a_neg;
               neg_d    = a_neg ^ b_neg;
               is_div_d = op[1];
               cnt_d    = CNT_W'(WIDTH);
               if (!op[1]) begin
                  state_d = S_MUL;
                  acc_d   = {{WIDTH{1'b0}}, abs_b};
               end else if (b == '0) begin
                  // HI/LO keep their old contents on a divide-by-zero.
                  state_d = S_DONE;
                  dz_d    = 1'b1;
               end else begin
                  state_d = S_DIV;
                  acc_d   = {{WIDTH{1'b0}}, abs_a};
                  rem_d   = '0;
               end
            end
         end
         S_MUL: begin
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DIV: begin
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               rem_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
               acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_FIX: begin
            state_d = S_DONE;
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            dz_d    = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers. Reset drops any operation that is in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
   assign done     = (state_q == S_DONE);
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit at WIDTH=32.
// Every expected value is computed by hand from the operand values.
module tb_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   always #5 clock = ~clock;

   muldiv_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   // Runs one operation from IDLE. lat counts the edges after E0 until done is seen (-1 on timeout).
   // bcnt counts the sampled cycles with busy high. The task returns one cycle after done.
   task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int bcnt, output logic dz,
                        output logic [31:0] rh, output logic [31:0] rl);
      op = o; a = av; b = bv; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; lat = 0; bcnt = 0;
      while (!done && lat < 200) begin
         if (busy) bcnt++;
         @(posedge clock); #1;
         lat++;
      end
      if (!done) lat = -1;
      dz = div_zero; rh = hi; rl = lo;
      @(posedge clock); #1;
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clock);
      #1;
      total++;
      if ({busy, done, div_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
         bad++;
         $display("FAIL reset: busy/done/dz=%b%b%b hi=%h lo=%h required 000 0 0", busy, done, div_zero, hi, lo);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_mult;
      int lat, bc; logic dz; logic [31:0] rh, rl;
      do_op(OP_MULT, 32'hFFFFFFFD, 32'h00000007, lat, bc, dz, rh, rl);
      total++;
      if (lat !== 34 || bc !== 34) begin
         bad++; $display("FAIL mult_latency: lat=%0d busy=%0d required 34/34", lat, bc);
      end
      total++;
      if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFEB || dz !== 1'b0) begin
         bad++; $display("FAIL mult_neg: hi=%h lo=%h dz=%b required FFFFFFFF FFFFFFEB 0", rh, rl, dz);
      end
      do_op(OP_MULT, 32'h80000000, 32'hFFFFFFFF, lat, bc, dz, rh, rl);
      total++;
      if (rh !== 32'h00000000 || rl !== 32'h80000000) begin
         bad++; $display("FAIL mult_min: hi=%h lo=%h required 00000000 80000000", rh, rl);
      end
   endtask

   task automatic test_div;
      int lat, bc; logic dz; logic [31:0] rh, rl;
      do_op(OP_DIV, 32'd100, 32'd7, lat, bc, dz, rh, rl);
      total++;
      if (rh !== 32'd2 || rl !== 32'd14) begin
         bad++; $display("FAIL div_pos: hi=%h lo=%h required 00000002 0000000e", rh, rl);
      end
      do_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, bc, dz, rh, rl);
      total++;
      if (rh !== 32'h00000001 || rl !== 32'hFFFFFFFD) begin
         bad++; $display("FAIL div_negb: hi=%h lo=%h required 00000001 FFFFFFFD", rh, rl);
      end
      do_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002, lat, bc, dz, rh, rl);
      total++;
      if (lat !== 34 || dz !== 1'b0) begin
         bad++; $display("FAIL div_latency: lat=%0d dz=%b required 34 0", lat, dz);
      end
      total++;
      if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFFD) begin
         bad++; $display("FAIL div_nega: hi=%h lo=%h required FFFFFFFF FFFFFFFD", rh, rl);
      end
   endtask

   task automatic test_div_zero;
      int lat, bc; logic dz; logic [31:0] rh, rl;
      do_op(OP_DIV, 32'h00000005, 32'h0, lat, bc, dz, rh, rl);
      total++;
      if (lat !== 0 || bc !== 0 || dz !== 1'b1) begin
         bad++; $display("FAIL div_zero_flag: lat=%0d busy=%0d dz=%b required 0 0 1", lat, bc, dz);
      end
      total++;
      if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFFD) begin
         bad++; $display("FAIL div_zero_hold: hi=%h lo=%h required FFFFFFFF FFFFFFFD", rh, rl);
      end
      total++;
      if (div_zero !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL div_zero_clear: dz=%b done=%b required 0 0", div_zero, done);
      end
   endtask

   task automatic test_min_neg1;
      int lat, bc; logic dz; logic [31:0] rh, rl;
      do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc, dz, rh, rl);
      total++;
      if (rh !== 32'h00000000 || rl !== 32'h80000000 || dz !== 1'b0) begin
         bad++; $display("FAIL min_neg1: hi=%h lo=%h dz=%b required 00000000 80000000 0", rh, rl, dz);
      end
   endtask

   task automatic test_ignore_start;
      int lat; int quiet;
      op = OP_MULT; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clock); #1;                       // E0
      start = 1'b0; lat = 0;
      repeat (4) @(posedge clock);
      #1;
      start = 1'b1; a = 32'd9; op = OP_DIV; b = 32'd0;
      @(posedge clock); #1;                       // E0+5
      start = 1'b0;
      lat = 5;
      while (!done && lat < 200) begin
         @(posedge clock); #1;
         lat++;
      end
      total++;
      if (lat !== 34 || hi !== 32'h0 || lo !== 32'h0000000C || div_zero !== 1'b0) begin
         bad++; $display("FAIL ignore_start: lat=%0d hi=%h lo=%h dz=%b required 34 0 0000000c 0", lat, hi, lo, div_zero);
      end
      quiet = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (done || busy) quiet++;
      end
      total++;
      if (quiet !== 0) begin
         bad++; $display("FAIL no_queued_start: active cycles=%0d required 0", quiet);
      end
   endtask

   task automatic test_reset_midop;
      int seen;
      op = OP_MULT; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clock); #1;                       // E0
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         bad++; $display("FAIL reset_midop: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock); #1;
         if (done) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++; $display("FAIL reset_no_done: done cycles=%0d required 0", seen);
      end
   endtask

   task automatic test_unsigned_cfg;
      int lat, bc; logic dz; logic [31:0] rh, rl;
      logic [31:0] exp_mh, exp_ml, exp_dh, exp_dl;
`ifdef MULDIV_UNSIGNED_EN
      exp_mh = 32'hFFFFFFFE; exp_ml = 32'h00000001;
      exp_dh = 32'h00000001; exp_dl = 32'h7FFFFFFF;
`else
      exp_mh = 32'h00000000; exp_ml = 32'h00000001;
      exp_dh = 32'hFFFFFFFF; exp_dl = 32'h00000000;
`endif
      do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, dz, rh, rl);
      total++;
      if (rh !== exp_mh || rl !== exp_ml || lat !== 34) begin
         bad++; $display("FAIL multu: hi=%h lo=%h lat=%0d required %h %h 34", rh, rl, lat, exp_mh, exp_ml);
      end
      do_op(OP_DIVU, 32'hFFFFFFFF, 32'h00000002, lat, bc, dz, rh, rl);
      total++;
      if (rh !== exp_dh || rl !== exp_dl || lat !== 34) begin
         bad++; $display("FAIL divu: hi=%h lo=%h lat=%0d required %h %h 34", rh, rl, lat, exp_dh, exp_dl);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_min_neg1();
      test_ignore_start();
      test_reset_midop();
      test_unsigned_cfg();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
